// File: rtl/mult_accum_if.sv
// Product-in / window-sum-out handshake bundle for mult_accum.
interface mult_accum_if #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [2*BITWIDTH-1:0]  prod;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic                          ovf;

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, sum, ovf
  );

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/mult_accum.sv
// Accumulates TERMS signed products into one window sum with valid/ready on both sides.
// Optional macro ACC_SAT_EN: saturating additions plus a sticky per-window ovf flag.
module mult_accum #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned TERMS     = 25,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mult_accum_if.slave   ma
);

  localparam int unsigned CW = (TERMS > 1) ? $clog2(TERMS) : 1;

  logic [CW-1:0]               cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] add_res;
  logic                        out_valid_q;
  logic                        in_ready_c;
  logic                        xfer;
  logic                        last;
  logic                        handoff;

  // Downstream back-pressure stalls the whole datapath while a result is unconsumed
  assign in_ready_c = !out_valid_q || ma.out_ready;
  assign xfer       = ma.in_valid && in_ready_c;
  assign handoff    = out_valid_q && ma.out_ready;
  assign last       = (cnt == CW'(TERMS - 1));
  assign prod_ext   = ACC_WIDTH'($signed(ma.prod[2*BITWIDTH-1:0]));

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide;
  logic                      sat_now;
  logic                      sat_flag;
  logic                      ovf_q;

  // One guard bit detects signed overflow; clamp toward the overflow direction
  always_comb begin
    wide    = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod_ext);
    sat_now = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    add_res = wide[ACC_WIDTH-1:0];
    if (sat_now) begin
      add_res = wide[ACC_WIDTH] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (xfer) begin
      if (last) begin
        ovf_q    <= sat_flag | sat_now;
        sat_flag <= 1'b0;
      end else begin
        sat_flag <= sat_flag | sat_now;
      end
    end
  end

  assign ma.ovf = ovf_q;
`else
  always_comb begin
    add_res = acc + prod_ext;
  end

  assign ma.ovf = 1'b0;
`endif

  // Window accumulation; a completing transfer overrides a same-cycle handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (handoff) begin
        out_valid_q <= 1'b0;
      end
      if (xfer) begin
        if (last) begin
          sum_q       <= add_res;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc <= add_res;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign ma.in_ready  = in_ready_c;
  assign ma.out_valid = out_valid_q;
  assign ma.sum       = sum_q;

endmodule
